// File: rtl/accum_dump_ctrl.sv
// Dump scheduler + snapshot buffer: dump_enable 1 cycle after a qualifying epoch, capture 2 cycles later.
// No backpressure; unread captures are overwritten and flagged by overrun. `ACCUM_OVR_CNT_EN adds ovr_count.
module accum_dump_ctrl #(
   parameter int NUM_ACC = 6,
   parameter int ACC_W   = 16,
   parameter int LEN_W   = 5
) (
   input  logic                     clk,
   input  logic                     rstn,
   input  logic                     ch_enable,
   input  logic                     epoch_in,
   input  logic [LEN_W-1:0]         int_len,
   input  logic [NUM_ACC*ACC_W-1:0] acc_in,
   output logic                     dump_enable,
   output logic [NUM_ACC*ACC_W-1:0] snap,
   output logic                     data_valid,
   input  logic                     rd_ack,
   output logic                     overrun,
   output logic [15:0]              dump_count,
   output logic [7:0]               ovr_count
);

   typedef enum logic [1:0] {IDLE, ARM, RUN} state_t;

   state_t           state;
   logic [LEN_W-1:0] epoch_cnt;
   logic [LEN_W-1:0] last_cnt;
   logic             cap_s1;
   logic             cap_s2;
   logic             capture;

   // int_len of 0 behaves as 1, so the terminal count is 0 in both cases
   assign last_cnt = (int_len == '0) ? '0 : int_len - 1'b1;
   assign capture  = cap_s2 & ch_enable;

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state       <= IDLE;
         epoch_cnt   <= '0;
         dump_enable <= 1'b0;
         cap_s1      <= 1'b0;
         cap_s2      <= 1'b0;
      end else begin
         dump_enable <= 1'b0;
         cap_s1      <= 1'b0;
         cap_s2      <= cap_s1 & ch_enable;
         if (!ch_enable) begin
            state     <= IDLE;
            epoch_cnt <= '0;
         end else begin
            case (state)
               IDLE: state <= ARM;
               ARM: begin
                  // first dump only flushes a partial integration, so no capture
                  if (epoch_in) begin
                     dump_enable <= 1'b1;
                     epoch_cnt   <= '0;
                     state       <= RUN;
                  end
               end
               RUN: begin
                  if (epoch_in) begin
                     if (epoch_cnt >= last_cnt) begin
                        epoch_cnt   <= '0;
                        dump_enable <= 1'b1;
                        cap_s1      <= 1'b1;
                     end else begin
                        epoch_cnt <= epoch_cnt + 1'b1;
                     end
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         snap       <= '0;
         data_valid <= 1'b0;
         overrun    <= 1'b0;
         dump_count <= '0;
      end else if (capture) begin
         snap       <= acc_in;
         data_valid <= 1'b1;
         dump_count <= dump_count + 16'd1;
         // an ack in the capture cycle means the previous data was consumed
         if (rd_ack)
            overrun <= 1'b0;
         else if (data_valid)
            overrun <= 1'b1;
      end else if (rd_ack && data_valid) begin
         data_valid <= 1'b0;
         overrun    <= 1'b0;
      end
   end

`ifdef ACCUM_OVR_CNT_EN
   logic ovr_event;
   assign ovr_event = capture & data_valid & ~rd_ack;

   always_ff @(posedge clk) begin
      if (!rstn)
         ovr_count <= '0;
      else if (ovr_event && ovr_count != 8'hFF)
         ovr_count <= ovr_count + 8'd1;
   end
`else
   assign ovr_count = 8'd0;
`endif

endmodule

// File: tb/tb_accum_dump_ctrl.sv
// Randomized directed bench for accum_dump_ctrl against an epoch/event-queue reference model.
module tb_accum_dump_ctrl;
   localparam int NUM_ACC = 6;
   localparam int ACC_W   = 16;
   localparam int LEN_W   = 5;
   localparam int SW      = NUM_ACC * ACC_W;

   logic          clk = 1'b0;
   logic          rstn;
   logic          ch_enable;
   logic          epoch_in;
   logic [LEN_W-1:0] int_len;
   logic [SW-1:0] acc_in;
   logic          dump_enable;
   logic [SW-1:0] snap;
   logic          data_valid;
   logic          rd_ack;
   logic          overrun;
   logic [15:0]   dump_count;
   logic [7:0]    ovr_count;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   accum_dump_ctrl #(.NUM_ACC(NUM_ACC), .ACC_W(ACC_W), .LEN_W(LEN_W)) dut (
      .clk(clk), .rstn(rstn), .ch_enable(ch_enable), .epoch_in(epoch_in),
      .int_len(int_len), .acc_in(acc_in), .dump_enable(dump_enable), .snap(snap),
      .data_valid(data_valid), .rd_ack(rd_ack), .overrun(overrun),
      .dump_count(dump_count), .ovr_count(ovr_count)
   );

   // Reference model: phase 0 = disabled, 1 = waiting for flush epoch, 2 = integrating
   int            cyc_n = 0;
   int            phase;
   int            since;
   int            due[$];
   logic          e_dump, e_dv, e_ovr;
   logic [SW-1:0] e_snap;
   int            e_dc, e_oc;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_all();
      chk("dump_enable", dump_enable, e_dump);
      chk("data_valid", data_valid, e_dv);
      chk("overrun", overrun, e_ovr);
      chk("dump_count", dump_count, e_dc);
      chk("snap", snap, e_snap);
`ifdef ACCUM_OVR_CNT_EN
      chk("ovr_count", ovr_count, e_oc);
`else
      chk("ovr_count", ovr_count, 0);
`endif
   endtask

   task automatic new_acc();
      for (int i = 0; i < NUM_ACC; i++) acc_in[i*ACC_W +: ACC_W] = 16'($urandom);
   endtask

   task automatic model_reset();
      phase = 0; since = 0; due.delete();
      e_dump = 0; e_dv = 0; e_ovr = 0; e_snap = '0; e_dc = 0; e_oc = 0;
   endtask

   // One clock: predict effects of this cycle's inputs, clock, then compare
   task automatic tick();
      bit cap;
      int eff;
      cap = 0;
      if (due.size() > 0 && due[0] == cyc_n) begin
         cap = ch_enable;
         void'(due.pop_front());
      end
      e_dump = 0;
      eff = (int_len == 0) ? 1 : int'(int_len);
      if (!ch_enable) begin
         phase = 0; since = 0; due.delete();
      end else if (phase == 0) begin
         phase = 1;
      end else if (epoch_in) begin
         if (phase == 1) begin
            e_dump = 1; since = 0; phase = 2;
         end else begin
            since++;
            if (since >= eff) begin
               e_dump = 1; since = 0; due.push_back(cyc_n + 2);
            end
         end
      end
      if (cap) begin
         if (e_dv && !rd_ack) begin
            e_ovr = 1;
            if (e_oc < 255) e_oc++;
         end else if (rd_ack) begin
            e_ovr = 0;
         end
         e_snap = acc_in; e_dv = 1; e_dc = (e_dc + 1) % 65536;
      end else if (rd_ack && e_dv) begin
         e_dv = 0; e_ovr = 0;
      end
      @(posedge clk); #1;
      cyc_n++;
      chk_all();
      epoch_in = 0; rd_ack = 0;
      new_acc();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic epoch();
      epoch_in = 1;
      tick();
   endtask

   task automatic do_reset();
      rstn = 0;
      @(posedge clk); #1;
      cyc_n++;
      model_reset();
      chk_all();
      rstn = 1;
      new_acc();
   endtask

   initial begin
      int dc0;
      rstn = 0; ch_enable = 0; epoch_in = 0; rd_ack = 0; int_len = 1; new_acc();

      // Reset state
      do_reset();
      idle(2);

      // int_len=1, epochs every 10 cycles: first is an uncaptured flush
      ch_enable = 1;
      tick();
      dc0 = e_dc;
      for (int k = 0; k < 6; k++) begin
         epoch();
         idle(4);
         rd_ack = 1'($urandom_range(0, 1));
         idle(5);
      end
      chk("len1_captures", dump_count, 16'(dc0 + 5));

      // int_len=4, 9 epochs after ARM: dumps on ARM epoch, epoch 4 and 8
      ch_enable = 0; tick();
      int_len = 4; ch_enable = 1; tick();
      dc0 = e_dc;
      for (int k = 0; k < 9; k++) begin
         epoch();
         idle(3);
      end
      idle(3);
      chk("len4_captures", dump_count, 16'(dc0 + 2));

      // Shrink int_len mid-integration: next epoch must dump
      ch_enable = 0; tick();
      int_len = 10; ch_enable = 1; tick();
      epoch(); idle(2);
      for (int k = 0; k < 6; k++) begin
         epoch(); idle(1);
      end
      int_len = 3;
      epoch();
      chk("shrink_dump", dump_enable, 1'b1);
      idle(4);
      for (int k = 0; k < 3; k++) begin
         epoch(); idle(2);
      end

      // Two captures without ack -> overrun, then ack clears
      rd_ack = 1; tick(); idle(2);
      int_len = 1;
      epoch(); idle(5);
      epoch(); idle(5);
      chk("ovr_set", overrun, 1'b1);
      chk("ovr_snap", snap, e_snap);
      rd_ack = 1; tick();
      chk("ack_clr_dv", data_valid, 1'b0);
      chk("ack_clr_ovr", overrun, 1'b0);

      // Ack exactly in the capture cycle with unread data
      epoch(); idle(5);
      epoch(); tick();
      rd_ack = 1; tick();
      chk("ackcap_dv", data_valid, 1'b1);
      chk("ackcap_ovr", overrun, 1'b0);
      idle(3);

      // Drop ch_enable at T+1: capture cancelled; re-arm gives uncaptured flush
      dc0 = e_dc;
      epoch();
      ch_enable = 0; tick();
      idle(4);
      chk("cancel_dc", dump_count, 16'(dc0));
      ch_enable = 1; tick();
      epoch();
      chk("rearm_dump", dump_enable, 1'b1);
      idle(4);
      chk("rearm_dc", dump_count, 16'(dc0));

      // Randomized traffic
      for (int i = 0; i < 400; i++) begin
         if (i % 50 == 0) int_len = LEN_W'($urandom_range(0, 5));
         epoch_in  = ($urandom_range(0, 3) == 0);
         rd_ack    = ($urandom_range(0, 5) == 0);
         ch_enable = ($urandom_range(0, 59) != 0);
         tick();
      end
      ch_enable = 1;

      // Reset while holding unread data
      int_len = 1; tick(); tick();
      epoch(); epoch(); idle(4);
      chk("pre_reset_dv", data_valid, 1'b1);
      do_reset();
      idle(2);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/accum_dump_ctrl.md
# accum_dump_ctrl

Dump scheduler and readout buffer for one tracking channel's bank of correlator accumulators. It counts code-epoch pulses and issues a single-cycle dump_enable to all accumulators every int_len epochs. One cycle after each dump it snapshots the latched accumulations into a holding bank and presents them to the processor bus with a valid/ack handshake and overrun detection. It sits between the channel's code generator (epoch source) and the accumulator bank / register interface.

## Interface
- NUM_ACC, 6: number of accumulators served (I/Q × early/prompt/late).
- ACC_W, 16: accumulator width, signed.
- LEN_W, 5: width of int_len; maximum integration 2^LEN_W−1 epochs.
- clk  in  1  clock.
- rstn  in  1  reset, synchronous, active-low.
- ch_enable  in  1  channel enable; low forces IDLE.
- epoch_in  in  1  single-cycle pulse at each code epoch.
- int_len  in  LEN_W  integration length in epochs; 0 treated as 1.
- acc_in  in  NUM_ACC×ACC_W  latched accumulator outputs, packed, index 0 at LSBs.
- dump_enable  out  1  single-cycle dump strobe to all accumulators.
- snap  out  NUM_ACC×ACC_W  captured accumulations.
- data_valid  out  1  snap holds unread data.
- rd_ack  in  1  single-cycle pulse: processor has read snap.
- overrun  out  1  sticky: a capture overwrote unread data.
- dump_count  out  16  wrapping count of captured dumps.
- ovr_count  out  8  overrun event count (see Configuration).

## Operation
- States: IDLE, ARM, RUN.
- IDLE: epoch_cnt=0, no dumps, no captures. ch_enable=1 → ARM.
- ARM: first epoch_in issues dump_enable (flushes partial integration), no capture; epoch_cnt=0; → RUN.
- RUN: each epoch_in increments epoch_cnt; when epoch_cnt ≥ eff_len−1 (eff_len = max(int_len,1)) on an epoch: epoch_cnt←0, issue dump_enable, schedule capture.
- int_len changes take effect immediately; the ≥ compare guarantees a dump on the next epoch if the count already exceeds the new length.
- ch_enable=0 in any state → IDLE next cycle; a scheduled-but-unperformed capture is cancelled; snap, data_valid, overrun, and the counters are retained.
- Capture: snap←acc_in (all NUM_ACC words same cycle), data_valid←1, dump_count←dump_count+1 (wraps 0xFFFF→0).
- Capture while data_valid=1 and no rd_ack that cycle: overrun←1, snap overwritten with new data.
- rd_ack with no capture same cycle: data_valid←0, overrun←0.
- rd_ack and capture same cycle: capture wins; data_valid stays 1; overrun←0 (the previous data was read).
- rd_ack while data_valid=0: ignored.
- epoch_in while a capture is in flight is counted normally; back-to-back epochs with eff_len=1 produce one dump per epoch.

## Timing
- epoch_in high in cycle T (dump condition met) → dump_enable high in cycle T+1 only (registered).
- Accumulators latch at the end of T+1; acc_in is valid in T+2; capture occurs at the end of T+2; snap and data_valid are visible from T+3.
- rd_ack in cycle R → data_valid low from R+1.
- ch_enable rise in cycle E → ARM from E+1; an epoch in E is ignored.
- Reset values: state IDLE, dump_enable 0, snap 0, data_valid 0, overrun 0, dump_count 0, ovr_count 0, epoch_cnt 0.
- Reset mid-pipeline cancels any pending dump or capture; dump_enable is low in the cycle after reset is sampled.

## Configuration
- ACCUM_OVR_CNT_EN defined: ovr_count increments on every overrun event, saturates at 255, and is cleared only by reset.
- ACCUM_OVR_CNT_EN undefined: the counter logic is absent and ovr_count is constant 0. Sticky overrun behaviour is unchanged.

## Test plan
- Set int_len=1 and ch_enable=1, then send epochs every 10 cycles: the first epoch gives a dump with no capture. Every later epoch at T gives dump_enable at T+1, snap=acc_in(T+2), and data_valid at T+3. dump_count increments once per epoch.
- Set int_len=4 and send 9 epochs after ARM: dumps occur on the ARM epoch, epoch 4, and epoch 8. Exactly 2 captures.
- Run int_len=10 with epoch_cnt=6, then change int_len to 3: a dump occurs on the next epoch, and epoch_cnt returns to 0.
- Send two captures without rd_ack: overrun=1, snap holds the second values, and ovr_count=1 with the macro defined (0 without). A following rd_ack clears data_valid and overrun.
- Pulse rd_ack in the exact capture cycle (T+2): data_valid stays 1, overrun stays 0, and snap updates.
- Drop ch_enable in cycle T+1 after a dump: no capture, and dump_count is unchanged. Re-enable → ARM, and the first epoch gives an uncaptured dump. Reset with data_valid=1 → all outputs 0 the next cycle.
